// File: rtl/io_bus_pkg.sv
// Shared types for the core-to-device IO bridge.
// Request bundle, FSM states and the error fill pattern.
package io_bus_pkg;

    localparam int IO_ADDR_W = 32;
    localparam int IO_BUS_W  = 512;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP,
        RESP
    } io_bridge_state_t;

    typedef struct packed {
        logic                 write;
        logic [IO_ADDR_W-1:0] address;
        logic [IO_BUS_W-1:0]  data;
    } io_req_t;

    localparam logic [IO_BUS_W-1:0] IO_ERR_DATA = '1;

endpackage

// File: rtl/io_req_fifo.sv
// Synchronous request FIFO with full/empty flags.
// Push and pop may occur in the same cycle.
module io_req_fifo
    import io_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  io_req_t push_req,
    input  logic    pop,
    output io_req_t pop_req,
    output logic    full,
    output logic    empty
);

    localparam int PW = $clog2(DEPTH);

    io_req_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_req = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_bus_bridge.sv
// Single-outstanding bridge from core IO requests to the device port.
// Writes are posted; reads wait for a response or a timeout.
module io_bus_bridge
    import io_bus_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = IO_ADDR_W,
    parameter int BUS_WIDTH      = IO_BUS_W,
    parameter int REQ_FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     core_req_valid,
    output logic                     core_req_ready,
    input  logic                     core_req_write,
    input  logic [ADDRESS_WIDTH-1:0] core_req_address,
    input  logic [BUS_WIDTH-1:0]     core_req_data,
    output logic                     core_resp_valid,
    input  logic                     core_resp_ready,
    output logic [BUS_WIDTH-1:0]     core_resp_data,
    output logic                     core_resp_error,
    output logic [ADDRESS_WIDTH-1:0] n2m_request_address,
    output logic [BUS_WIDTH-1:0]     n2m_request_data,
    output logic                     n2m_request_read,
    output logic                     n2m_request_write,
    output logic                     mc_avail_o,
    input  logic                     m2n_request_available,
    input  logic                     m2n_response_valid,
    input  logic [ADDRESS_WIDTH-1:0] m2n_response_address,
    input  logic [BUS_WIDTH-1:0]     m2n_response_data
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    io_bridge_state_t state;
    io_bridge_state_t state_nx;
    io_req_t          push_req;
    io_req_t          head;
    io_req_t          iss;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [TW-1:0]    tmo_cnt;
    logic             resp_hit;
    logic             tmo_hit;

    assign push_req.write   = core_req_write;
    assign push_req.address = core_req_address;
    assign push_req.data    = core_req_data;

    io_req_fifo #(
        .DEPTH (REQ_FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (core_req_valid),
        .push_req (push_req),
        .pop      (pop),
        .pop_req  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign core_req_ready      = ~fifo_full;
    assign pop                 = (state == IDLE) & ~fifo_empty;
    assign mc_avail_o          = (state == WAIT_RESP);
    assign core_resp_valid     = (state == RESP);
    assign n2m_request_address = iss.address;
    assign n2m_request_data    = iss.data;
    assign resp_hit = (state == WAIT_RESP) & m2n_response_valid;
    // Last WAIT_RESP cycle: counter is about to reach TIMEOUT_CYCLES.
    assign tmo_hit  = (state == WAIT_RESP) &
                      (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nx          = state;
        n2m_request_read  = 1'b0;
        n2m_request_write = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty)
                    state_nx = ISSUE;
            end
            ISSUE: begin
                if (m2n_request_available) begin
                    n2m_request_read  = ~iss.write;
                    n2m_request_write = iss.write;
                    state_nx = iss.write ? IDLE : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (resp_hit || tmo_hit)
                    state_nx = RESP;
            end
            RESP: begin
                if (core_resp_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            iss             <= '0;
            tmo_cnt         <= '0;
            core_resp_data  <= '0;
            core_resp_error <= 1'b0;
        end else begin
            state <= state_nx;
            if (pop)
                iss <= head;
            if (state == ISSUE)
                tmo_cnt <= '0;
            else if (state == WAIT_RESP)
                tmo_cnt <= tmo_cnt + 1'b1;
            // A real response beats a coincident timeout.
            if (resp_hit) begin
                core_resp_data  <= m2n_response_data;
                core_resp_error <= (m2n_response_address != iss.address);
            end else if (tmo_hit) begin
                core_resp_data  <= IO_ERR_DATA;
                core_resp_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_bus_bridge.sv
// Directed bench for io_bus_bridge with hand-computed expectations.
// Depth 4 FIFO, 8-cycle read timeout.
module tb_io_bus_bridge;

    localparam int AW = 32;
    localparam int BW = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          core_req_valid = 1'b0;
    logic          core_req_ready;
    logic          core_req_write = 1'b0;
    logic [AW-1:0] core_req_address = '0;
    logic [BW-1:0] core_req_data = '0;
    logic          core_resp_valid;
    logic          core_resp_ready = 1'b0;
    logic [BW-1:0] core_resp_data;
    logic          core_resp_error;
    logic [AW-1:0] n2m_request_address;
    logic [BW-1:0] n2m_request_data;
    logic          n2m_request_read;
    logic          n2m_request_write;
    logic          mc_avail_o;
    logic          m2n_request_available = 1'b0;
    logic          m2n_response_valid = 1'b0;
    logic [AW-1:0] m2n_response_address = '0;
    logic [BW-1:0] m2n_response_data = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int rd_n = 0;
    int wr_n = 0;
    logic [AW-1:0] wr_log [64];

    always #5 clk = ~clk;

    io_bus_bridge #(
        .ADDRESS_WIDTH  (AW),
        .BUS_WIDTH      (BW),
        .REQ_FIFO_DEPTH (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .core_req_valid        (core_req_valid),
        .core_req_ready        (core_req_ready),
        .core_req_write        (core_req_write),
        .core_req_address      (core_req_address),
        .core_req_data         (core_req_data),
        .core_resp_valid       (core_resp_valid),
        .core_resp_ready       (core_resp_ready),
        .core_resp_data        (core_resp_data),
        .core_resp_error       (core_resp_error),
        .n2m_request_address   (n2m_request_address),
        .n2m_request_data      (n2m_request_data),
        .n2m_request_read      (n2m_request_read),
        .n2m_request_write     (n2m_request_write),
        .mc_avail_o            (mc_avail_o),
        .m2n_request_available (m2n_request_available),
        .m2n_response_valid    (m2n_response_valid),
        .m2n_response_address  (m2n_response_address),
        .m2n_response_data     (m2n_response_data)
    );

    always @(negedge clk) begin
        if (n2m_request_read)
            rd_n <= rd_n + 1;
        if (n2m_request_write) begin
            if (wr_n < 64)
                wr_log[wr_n] <= n2m_request_address;
            wr_n <= wr_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [BW-1:0] obs,
                       input logic [BW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic w, input logic [AW-1:0] a,
                        input logic [BW-1:0] d);
        core_req_valid   = 1'b1;
        core_req_write   = w;
        core_req_address = a;
        core_req_data    = d;
        step();
        core_req_valid   = 1'b0;
    endtask

    task automatic wait_avail(input string tag);
        int k;
        k = 0;
        while (!mc_avail_o && k < 20) begin
            step();
            k++;
        end
        chk(tag, mc_avail_o, 1);
    endtask

    task automatic handshake();
        core_resp_ready = 1'b1;
        step();
        core_resp_ready = 1'b0;
    endtask

    initial begin
        int base;
        int k;
        int rd_base;
        int wr_base;
        logic [BW-1:0] d5;
        logic [BW-1:0] ones;

        ones = '1;
        d5 = '0;
        d5[7:0] = 8'h55;
        d5[511:504] = 8'hC3;

        repeat (3) step();
        chk("rst_req_ready", core_req_ready, 1);
        chk("rst_resp_valid", core_resp_valid, 0);
        chk("rst_mc_avail", mc_avail_o, 0);
        chk("rst_rd", n2m_request_read, 0);
        chk("rst_wr", n2m_request_write, 0);
        chk("rst_addr", n2m_request_address, 0);
        chk("rst_resp_data", core_resp_data, 0);
        chk("rst_resp_err", core_resp_error, 0);

        reset = 1'b0;
        m2n_request_available = 1'b1;
        step();

        // Single read, device answers three cycles after the pulse
        push(1'b0, 32'h1000, '0);
        step();
        chk("t1_rd_pulse", n2m_request_read, 1);
        chk("t1_no_wr", n2m_request_write, 0);
        chk("t1_addr", n2m_request_address, 32'h1000);
        step();
        chk("t1_rd_single", n2m_request_read, 0);
        chk("t1_mc_avail", mc_avail_o, 1);
        chk("t1_addr_hold", n2m_request_address, 32'h1000);
        step();
        step();
        chk("t1_no_resp_yet", core_resp_valid, 0);
        m2n_response_valid   = 1'b1;
        m2n_response_address = 32'h1000;
        m2n_response_data    = 512'hF0;
        step();
        m2n_response_valid   = 1'b0;
        chk("t1_resp_valid", core_resp_valid, 1);
        chk("t1_resp_data", core_resp_data, 512'hF0);
        chk("t1_resp_err", core_resp_error, 0);
        chk("t1_mc_avail_off", mc_avail_o, 0);
        step();
        chk("t1_resp_hold", core_resp_valid, 1);
        chk("t1_data_hold", core_resp_data, 512'hF0);
        handshake();
        chk("t1_resp_done", core_resp_valid, 0);
        chk("t1_rd_count", rd_n, 1);

        // Posted write
        push(1'b1, 32'h2000, 512'hAB);
        step();
        chk("t2_wr_pulse", n2m_request_write, 1);
        chk("t2_no_rd", n2m_request_read, 0);
        chk("t2_addr", n2m_request_address, 32'h2000);
        chk("t2_data", n2m_request_data, 512'hAB);
        step();
        chk("t2_wr_single", n2m_request_write, 0);
        chk("t2_no_resp", core_resp_valid, 0);
        chk("t2_wr_count", wr_n, 1);

        // Device response while idle must be ignored
        m2n_response_valid   = 1'b1;
        m2n_response_address = 32'h2000;
        m2n_response_data    = 512'h77;
        step();
        m2n_response_valid   = 1'b0;
        chk("ign_resp_valid", core_resp_valid, 0);
        chk("ign_resp_data", core_resp_data, 512'hF0);

        // FIFO fill while the device is stalled
        m2n_request_available = 1'b0;
        base = wr_n;
        push(1'b1, 32'h3000, 512'h30);
        step();
        chk("t3_stall", n2m_request_write, 0);
        for (int i = 1; i <= 4; i++) begin
            chk("t3_ready_pre", core_req_ready, 1);
            push(1'b1, 32'h3000 + 32'(i * 16), 512'(i));
        end
        chk("t3_full", core_req_ready, 0);
        core_req_valid   = 1'b1;
        core_req_write   = 1'b1;
        core_req_address = 32'h3050;
        core_req_data    = 512'h5;
        step();
        chk("t3_full_hold", core_req_ready, 0);
        m2n_request_available = 1'b1;
        k = 0;
        while (!core_req_ready && k < 20) begin
            step();
            k++;
        end
        chk("t3_ready_back", core_req_ready, 1);
        step();
        core_req_valid = 1'b0;
        k = 0;
        while (wr_n < base + 6 && k < 100) begin
            step();
            k++;
        end
        repeat (5) step();
        chk("t3_count", wr_n, base + 6);
        for (int i = 0; i < 6; i++)
            chk("t3_order", wr_log[base + i], 32'h3000 + 32'(i * 16));

        // Read timeout: response 8 cycles after entering WAIT_RESP
        push(1'b0, 32'h4000, '0);
        step();
        chk("t4_rd_pulse", n2m_request_read, 1);
        step();
        chk("t4_enter_wait", mc_avail_o, 1);
        repeat (7) step();
        chk("t4_pre_tmo_valid", core_resp_valid, 0);
        chk("t4_pre_tmo_avail", mc_avail_o, 1);
        step();
        chk("t4_tmo_valid", core_resp_valid, 1);
        chk("t4_tmo_data", core_resp_data, ones);
        chk("t4_tmo_err", core_resp_error, 1);
        handshake();
        chk("t4_done", core_resp_valid, 0);

        // Address mismatch on the response
        push(1'b0, 32'h1000, '0);
        wait_avail("t5_wait");
        m2n_response_valid   = 1'b1;
        m2n_response_address = 32'h1004;
        m2n_response_data    = d5;
        step();
        m2n_response_valid   = 1'b0;
        chk("t5_valid", core_resp_valid, 1);
        chk("t5_err", core_resp_error, 1);
        chk("t5_data", core_resp_data, d5);
        handshake();

        // Reset during WAIT_RESP with a write still queued
        push(1'b0, 32'h5000, '0);
        push(1'b1, 32'h5100, 512'h51);
        wait_avail("t6_wait");
        rd_base = rd_n;
        wr_base = wr_n;
        reset = 1'b1;
        #1;
        chk("t6_rst_avail", mc_avail_o, 0);
        chk("t6_rst_ready", core_req_ready, 1);
        chk("t6_rst_valid", core_resp_valid, 0);
        chk("t6_rst_addr", n2m_request_address, 0);
        chk("t6_rst_data", n2m_request_data, 0);
        chk("t6_rst_rdata", core_resp_data, 0);
        chk("t6_rst_err", core_resp_error, 0);
        step();
        reset = 1'b0;
        m2n_response_valid   = 1'b1;
        m2n_response_address = 32'h5000;
        m2n_response_data    = 512'h99;
        step();
        m2n_response_valid   = 1'b0;
        chk("t6_late_valid", core_resp_valid, 0);
        chk("t6_late_avail", mc_avail_o, 0);
        repeat (6) step();
        chk("t6_flushed_wr", wr_n, wr_base);
        chk("t6_no_rd", rd_n, rd_base);
        chk("t6_no_resp", core_resp_valid, 0);
        chk("t6_rdata", core_resp_data, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
